// File: rtl/lfsr_offset_search.sv
// Locates a received LFSR word by stepping ENGINES seeded LFSRs in parallel, each over SEG_LEN positions.
// Latency: match at iteration i -> done i+2 cycles after start; timeout SEG_LEN+1; zero data 1. No backpressure: start is ignored while busy.
module lfsr_offset_search #(
    parameter int WIDTH    = 17,
    parameter int ENGINES  = 4,
    parameter int SEG_LEN  = 29970,
    parameter int OFFSET_W = 17,
    parameter int IDX_W    = 2
) (
    input  logic                       clk_72MHz,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [WIDTH-1:0]           polynomial,
    input  logic [WIDTH-1:0]           data,
    input  logic [ENGINES*WIDTH-1:0]   seeds,
    output logic                       busy,
    output logic                       done,
    output logic                       found,
    output logic [OFFSET_W-1:0]        offset,
    output logic [IDX_W-1:0]           match_engine
);

    localparam int ITER_W = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(SEG_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t              state_q;
    logic [ITER_W-1:0]   iter_q;
    logic [WIDTH-1:0]    polynomial_q;
    logic [WIDTH-1:0]    data_q;
    logic [WIDTH-1:0]    eng_q [ENGINES];
    logic [WIDTH-1:0]    eng_d [ENGINES];
    logic                busy_q;
    logic                done_q;
    logic                found_q;
    logic [OFFSET_W-1:0] offset_q;
    logic [IDX_W-1:0]    match_q;

    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic [OFFSET_W-1:0] hit_off;

    // Scan from the top so the lowest matching engine is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_off = '0;
        for (int k = ENGINES - 1; k >= 0; k--) begin
            if (eng_q[k] == data_q) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
                hit_off = OFFSET_W'(k * SEG_LEN) + OFFSET_W'(iter_q);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < ENGINES; k++) begin
            eng_d[k] = eng_q[k];
            if (state_q == S_LOAD) begin
                eng_d[k] = seeds[k*WIDTH +: WIDTH];
            end else if (state_q == S_RUN) begin
                eng_d[k] = {eng_q[k][WIDTH-2:0], ^(eng_q[k] & polynomial_q)};
            end
        end
    end

    // Datapath registers carry no reset: they are always reloaded in LOAD before use.
    always_ff @(posedge clk_72MHz) begin
        for (int k = 0; k < ENGINES; k++) begin
            eng_q[k] <= eng_d[k];
        end
        if (state_q == S_LOAD) begin
            polynomial_q <= polynomial;
            data_q       <= data;
        end
    end

    always_ff @(posedge clk_72MHz) begin
        if (rst) begin
            state_q  <= S_IDLE;
            iter_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            offset_q <= '0;
            match_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    iter_q <= '0;
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (data == '0) begin
                        found_q  <= 1'b0;
                        offset_q <= '0;
                        match_q  <= '0;
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (hit) begin
                        found_q  <= 1'b1;
                        offset_q <= hit_off;
                        match_q  <= hit_idx;
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (iter_q == ITER_LAST) begin
                        found_q  <= 1'b0;
                        offset_q <= '0;
                        match_q  <= '0;
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        iter_q <= iter_q + ITER_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign found        = found_q;
    assign offset       = offset_q;
    assign match_engine = match_q;

endmodule

// File: doc/lfsr_offset_search.md
# lfsr_offset_search

Parametrised successor to the four-engine offset finder, used in the FPGA tracker. It recovers the position (offset) of a received LFSR word within a polynomial's sequence by stepping `ENGINES` LFSR instances in parallel. Each instance starts from a caller-supplied seed and covers its own `SEG_LEN`-long segment. It sits between the lighthouse bit decoder (which supplies `polynomial`/`data`) and the angle computation (which consumes `offset`).

## Interface
- `WIDTH`, 17, LFSR/polynomial/data width.
- `ENGINES`, 4, number of parallel LFSR engines (≥1).
- `SEG_LEN`, 29970, iterations searched per engine (≥1).
- `OFFSET_W`, 17, offset width; must satisfy 2^OFFSET_W ≥ ENGINES*SEG_LEN.
- `IDX_W`, 2, engine index width; must satisfy 2^IDX_W ≥ ENGINES.

Ports:
- `clk_72MHz` in 1: the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request a search; sampled only in IDLE.
- `abort` in 1: cancel a search in progress.
- `polynomial` in WIDTH: feedback taps.
- `data` in WIDTH: word to locate.
- `seeds` in ENGINES*WIDTH: seed for engine k is at bits [k*WIDTH +: WIDTH].
- `busy` out 1: high in LOAD and RUN.
- `done` out 1: one-cycle pulse when a result is valid.
- `found` out 1: 1 if the word was located.
- `offset` out OFFSET_W: position within the full sequence.
- `match_engine` out IDX_W: index of the engine that matched.

## Operation
- LFSR step (all engines identical): `next = {v[WIDTH-2:0], ^(v & polynomial_q)}`.
- FSM states: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - `start`=1 → LOAD.
  - Otherwise stay in IDLE.
- **LOAD**
  - Register `polynomial_q`, `data_q` and all seeds into the engine value registers.
  - Clear the iteration counter `iter` (width ≥ clog2(SEG_LEN)).
  - If `data`==0 (unreachable by a maximal LFSR): `found`←0, `offset`←0, `match_engine`←0, → DONE.
  - Otherwise → RUN.
  - Input ports are not used after LOAD; callers may change them freely.
- **RUN**, each cycle:
  - Compare every engine's current value with `data_q`.
  - On any match, the lowest matching index k wins:
    - `found`←1
    - `match_engine`←k
    - `offset`←k*SEG_LEN + `iter`, computed at OFFSET_W width with no truncation
    - → DONE
  - Else if `iter`==SEG_LEN-1: `found`←0, `offset`←0, `match_engine`←0, → DONE.
  - Else step all engines and increment `iter`.
- **DONE**: `done`=1 for exactly this cycle, then unconditionally → IDLE.
- `found`, `offset` and `match_engine` hold their values until the next LOAD overwrites them.
- `abort`=1 in LOAD or RUN → IDLE next cycle.
  - No `done` pulse.
  - Result outputs are left unchanged.
  - `abort` is ignored in IDLE and DONE.
- `start` is ignored in LOAD, RUN and DONE; it is not queued.
- `rst` has priority over everything.
  - State → IDLE; `iter` → 0.
  - All outputs → 0: `busy`, `done`, `found`, `offset`, `match_engine`.
  - Engine registers are don't-care after reset; they are always reloaded in LOAD.

## Timing
- Clock edge E0 samples `start` in IDLE. LOAD executes at E1. RUN compares with `iter`=i at edge E(2+i).
- Match at iteration i: `done` is high in the cycle after E(2+i), i.e. i+2 cycles after E0.
- Timeout: `done` is high SEG_LEN+1 cycles after E0.
- `data`==0: `done` is high 1 cycle after E0.
- `busy` is high from the cycle after E0 through the last RUN cycle. It is low in the `done` cycle.
- The earliest next start is sampled in the cycle after `done`.
- Throughput is one compare per engine per cycle. Worst-case search covers ENGINES*SEG_LEN positions.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Default params, `polynomial`=17'h1d258, seeds {1, 17'he844, 17'h1f555, 17'h13786}, `data`=17'h1 → `done` at E0+2, `found`=1, `offset`=0, `match_engine`=0.
- Same setup, `data` = engine-1 value after 5 steps from 17'he844 → `done` at E0+7, `offset`=29975, `match_engine`=1. Also `data`=17'h13786 → `offset`=89910, `match_engine`=3.
- Engines 1 and 2 given the same seed, `data` equal to that seed → `match_engine`=1 (lowest index wins), `offset`=SEG_LEN.
- SEG_LEN=8, ENGINES=2, `data` chosen absent from both segments → `done` at E0+9, `found`=0, `offset`=0. Also `data`=0 → `done` at E0+1, `found`=0.
- `abort` at E0+10 of a long search → `busy` falls the next cycle, no `done` pulse, previous result still on the outputs. `start` pulses while `busy` are ignored (no restart).
- `rst` asserted mid-RUN, with `start` held high through the reset cycle → all outputs 0 the next cycle. After `rst` deasserts, a new search completes with correct latency.
